// File: rtl/sym_fold_pkg.sv
// Shared constants and helpers for the symmetric fold delay line.
// Width math and oPair slice placement live here.
package sym_fold_pkg;

  localparam int DW_DEF   = 3;
  localparam int NTAP_DEF = 21;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction

  function automatic int slice_lo(input int k, input int dw);
    return k * (dw + 1);
  endfunction

endpackage

// File: rtl/fold_pair_add.sv
// Registered signed pre-adder for one symmetric tap pair.
// Result is one bit wider than the inputs so it never overflows.
module fold_pair_add #(
  parameter int DW = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW:0]   sum
);

  // sign-extend both operands and add when the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= {a[DW-1], a} + {b[DW-1], b};
    end
  end

endmodule

// File: rtl/sym_fold_delay.sv
// Symmetric delay line with folded pair adders and full-tap sum.
// Accept -> taps (N), pairs (N+1), sum (N+2).
module sym_fold_delay
  import sym_fold_pkg::*;
#(
  parameter int  DW   = DW_DEF,
  parameter int  NTAP = NTAP_DEF,
  localparam int SW   = DW + clog2(NTAP),
  localparam int H    = (NTAP - 1) / 2,
  localparam int PW   = DW + 1
) (
  input  logic                   iClk12M,
  input  logic                   iRsn,
  input  logic                   iEnSample600k,
  input  logic                   iEnDelay,
  input  logic                   iClear,
  input  logic signed [DW-1:0]   iFirIn,
  output logic [(H+1)*PW-1:0]    oPair,
  output logic                   oPairValid,
  output logic signed [SW-1:0]   oSum,
  output logic                   oValid,
  output logic                   oFull
);

  localparam int CW = clog2(NTAP + 1);

  if ((NTAP % 2) == 0 || NTAP < 3 || DW < 2) begin : g_bad_param
    $error("sym_fold_delay: NTAP must be odd >= 3 and DW >= 2");
  end

  logic signed [DW-1:0] tap [NTAP];
  logic signed [PW-1:0] pair [H];
  logic signed [PW-1:0] mid;
  logic signed [SW-1:0] sum_c;
  logic [CW-1:0]        cnt;
  logic                 acc;
  logic                 pend1;
  logic                 pend2;

  assign acc   = iEnSample600k & iEnDelay & ~iClear;
  assign oFull = (cnt == CW'(NTAP));

  // delay line shifts one place per accepted sample
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NTAP; i++) tap[i] <= '0;
    end else if (iClear) begin
      for (int i = 0; i < NTAP; i++) tap[i] <= '0;
    end else if (acc) begin
      tap[0] <= iFirIn;
      for (int i = 1; i < NTAP; i++) tap[i] <= tap[i-1];
    end
  end

  // fill counter saturates once the line is full
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      cnt <= '0;
    end else if (iClear) begin
      cnt <= '0;
    end else if (acc && !oFull) begin
      cnt <= cnt + CW'(1);
    end
  end

  // pipeline tags and valid pulses; clear drops in-flight work
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      pend1      <= 1'b0;
      pend2      <= 1'b0;
      oPairValid <= 1'b0;
      oValid     <= 1'b0;
    end else if (iClear) begin
      pend1      <= 1'b0;
      pend2      <= 1'b0;
      oPairValid <= 1'b0;
      oValid     <= 1'b0;
    end else begin
      pend1      <= acc;
      pend2      <= pend1;
      oPairValid <= pend1 & oFull;
      oValid     <= oPairValid;
    end
  end

  for (genvar k = 0; k < H; k++) begin : g_pair
    fold_pair_add #(
      .DW(DW)
    ) u_pair (
      .clk  (iClk12M),
      .rst_n(iRsn),
      .en   (pend1),
      .clr  (iClear),
      .a    (tap[k]),
      .b    (tap[NTAP-1-k]),
      .sum  (pair[k])
    );
  end

  // centre tap has no partner; register it sign-extended
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      mid <= '0;
    end else if (iClear) begin
      mid <= '0;
    end else if (pend1) begin
      mid <= {tap[H][DW-1], tap[H]};
    end
  end

  // pack pair slices, centre tap in the top slice
  always_comb begin
    oPair = '0;
    for (int k = 0; k < H; k++) begin
      oPair[slice_lo(k, DW) +: PW] = pair[k];
    end
    oPair[slice_lo(H, DW) +: PW] = mid;
  end

  // full-width signed sum of all folded slices
  always_comb begin
    sum_c = SW'(mid);
    for (int k = 0; k < H; k++) begin
      sum_c = sum_c + SW'(pair[k]);
    end
  end

  // sum stage follows the pair stage by one edge
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      oSum <= '0;
    end else if (iClear) begin
      oSum <= '0;
    end else if (pend2) begin
      oSum <= sum_c;
    end
  end

endmodule

// File: tb/tb_sym_fold_delay.sv
// Self-checking bench for sym_fold_delay (DW=3, NTAP=21).
// Table-driven fills plus directed enable, clear, ramp and reset cases.
module tb_sym_fold_delay;

  localparam int DW   = 3;
  localparam int NTAP = 21;
  localparam int H    = 10;
  localparam int PW   = 4;
  localparam int SW   = 8;
  localparam int NR   = 40;

  typedef struct {
    int kind;
    int val;
    int exp_sum;
    int exp_p0;
    int exp_pn;
    int exp_mid;
  } fill_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en_s = 1'b0;
  logic                  en_d = 1'b0;
  logic                  clr = 1'b0;
  logic signed [DW-1:0]  din = '0;
  logic [(H+1)*PW-1:0]   pair;
  logic                  pv;
  logic signed [SW-1:0]  sum;
  logic                  valid;
  logic                  full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sym_fold_delay #(
    .DW  (DW),
    .NTAP(NTAP)
  ) dut (
    .iClk12M      (clk),
    .iRsn         (rst_n),
    .iEnSample600k(en_s),
    .iEnDelay     (en_d),
    .iClear       (clr),
    .iFirIn       (din),
    .oPair        (pair),
    .oPairValid   (pv),
    .oSum         (sum),
    .oValid       (valid),
    .oFull        (full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sl(input int k);
    logic [PW-1:0] s;
    s = pair[k*PW +: PW];
    return int'($signed(s));
  endfunction

  task automatic accept(input int v);
    en_s = 1'b1;
    en_d = 1'b1;
    din  = DW'(v);
    tick();
    en_s = 1'b0;
    en_d = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  fill_t tab [5];
  int    m [NTAP];
  int    exp_s [NR];
  int    exp_v [NR];

  initial begin
    int bad;
    int mcnt;
    int s;

    tab[0] = '{kind: 1, val: 1,  exp_sum: 1,   exp_p0: 1,  exp_pn: 0,  exp_mid: 0};
    tab[1] = '{kind: 1, val: -4, exp_sum: -4,  exp_p0: -4, exp_pn: 0,  exp_mid: 0};
    tab[2] = '{kind: 0, val: -4, exp_sum: -84, exp_p0: -8, exp_pn: -8, exp_mid: -4};
    tab[3] = '{kind: 0, val: 3,  exp_sum: 63,  exp_p0: 6,  exp_pn: 6,  exp_mid: 3};
    tab[4] = '{kind: 0, val: -1, exp_sum: -21, exp_p0: -2, exp_pn: -2, exp_mid: -1};

    // reset state
    #12;
    chk("rst sum", int'(sum), 0);
    chk("rst full", int'(full), 0);
    chk("rst valid", int'(valid | pv), 0);
    chk("rst pair", int'(pair != '0), 0);
    tick();
    rst_n = 1'b1;

    // table-driven fills
    for (int r = 0; r < 5; r++) begin
      bad = 0;
      do_clear();
      for (int i = 0; i < NTAP; i++) begin
        accept((tab[r].kind == 1 && i > 0) ? 0 : tab[r].val);
        if (pv || valid) bad++;
      end
      chk($sformatf("fill%0d early valid", r), bad, 0);
      chk($sformatf("fill%0d full", r), int'(full), 1);
      tick();
      chk($sformatf("fill%0d pv", r), int'(pv), 1);
      chk($sformatf("fill%0d pair0", r), sl(0), tab[r].exp_p0);
      for (int k = 1; k < H; k++)
        chk($sformatf("fill%0d pair%0d", r, k), sl(k), tab[r].exp_pn);
      chk($sformatf("fill%0d mid", r), sl(H), tab[r].exp_mid);
      tick();
      chk($sformatf("fill%0d valid", r), int'(valid), 1);
      chk($sformatf("fill%0d sum", r), int'(sum), tab[r].exp_sum);
      chk($sformatf("fill%0d pv end", r), int'(pv), 0);
      tick();
      chk($sformatf("fill%0d valid end", r), int'(valid), 0);
    end

    // strobe without chain enable must not move anything
    bad = 0;
    en_s = 1'b1;
    en_d = 1'b0;
    din  = 3'sd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pv || valid) bad++;
    end
    en_s = 1'b0;
    tick();
    tick();
    chk("noen valid", bad + int'(pv | valid), 0);
    chk("noen pair0", sl(0), -2);
    chk("noen mid", sl(H), -1);
    chk("noen sum", int'(sum), -21);
    chk("noen full", int'(full), 1);

    // clear beats a simultaneous accept
    clr  = 1'b1;
    en_s = 1'b1;
    en_d = 1'b1;
    din  = 3'sd3;
    tick();
    clr  = 1'b0;
    en_s = 1'b0;
    en_d = 1'b0;
    chk("clracc full", int'(full), 0);
    chk("clracc sum", int'(sum), 0);
    chk("clracc pair", int'(pair != '0), 0);
    tick();
    tick();
    chk("clracc stale", int'(valid | pv), 0);
    chk("clracc sum2", int'(sum), 0);
    for (int i = 0; i < NTAP - 1; i++) accept(1);
    chk("clracc 20 not full", int'(full), 0);
    accept(1);
    chk("clracc 21 full", int'(full), 1);
    tick();
    tick();
    chk("clracc valid", int'(valid), 1);
    chk("clracc sum21", int'(sum), 21);

    // continuous ramp against a reference model
    do_clear();
    mcnt = 0;
    for (int i = 0; i < NTAP; i++) m[i] = 0;
    for (int t = 0; t < NR + 2; t++) begin
      if (t < NR) begin
        for (int i = NTAP - 1; i > 0; i--) m[i] = m[i-1];
        m[0] = (t % 8) - 4;
        if (mcnt < NTAP) mcnt++;
        s = 0;
        for (int i = 0; i < NTAP; i++) s += m[i];
        exp_s[t] = s;
        exp_v[t] = (mcnt == NTAP) ? 1 : 0;
        en_s = 1'b1;
        en_d = 1'b1;
        din  = DW'(m[0]);
      end else begin
        en_s = 1'b0;
        en_d = 1'b0;
      end
      tick();
      if (t >= 2) begin
        chk($sformatf("ramp t%0d sum", t), int'(sum), exp_s[t-2]);
        chk($sformatf("ramp t%0d valid", t), int'(valid), exp_v[t-2]);
      end else begin
        chk($sformatf("ramp t%0d sum", t), int'(sum), 0);
        chk($sformatf("ramp t%0d valid", t), int'(valid), 0);
      end
    end
    en_s = 1'b0;
    en_d = 1'b0;

    // async reset mid-pipeline
    do_clear();
    for (int i = 0; i < 10; i++) accept(3);
    chk("pre-rst sum", int'(sum), 24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst sum", int'(sum), 0);
    chk("midrst full", int'(full), 0);
    chk("midrst valid", int'(valid | pv), 0);
    chk("midrst pair", int'(pair != '0), 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pv || valid) bad++;
    end
    chk("postrst stale", bad, 0);
    chk("postrst sum", int'(sum), 0);
    for (int i = 0; i < NTAP - 1; i++) accept(1);
    chk("refill 20 not full", int'(full), 0);
    accept(1);
    chk("refill 21 full", int'(full), 1);
    tick();
    tick();
    chk("refill valid", int'(valid), 1);
    chk("refill sum", int'(sum), 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sym_fold_delay.md
SYM_FOLD_DELAY -- requirements
Module: sym_fold_delay

Interface
REQ-001 Parameter: DW, 3, signed input sample width (>=2).
REQ-002 Parameter: NTAP, 21, delay-line length; SHALL be odd and >=3; H = (NTAP-1)/2 pairs.
REQ-003 Parameter: SW, DW+clog2(NTAP), full-sum width (derived, not overridable).
REQ-004 Ports:
- iClk12M  in  1  system clock.
- iRsn  in  1  reset; one clock; reset is asynchronous and active-low.
- iEnSample600k  in  1  sample strobe, one-cycle pulse.
- iEnDelay  in  1  chain enable; a sample is accepted only when iEnSample600k and iEnDelay are both high.
- iClear  in  1  synchronous flush.
- iFirIn  in  DW  signed input sample.
- oPair  out  (H+1)*(DW+1)  folded taps; slice k (k<H) = x[k]+x[NTAP-1-k]; slice H = centre tap, sign-extended.
- oPairValid  out  1  one-cycle pulse qualifying oPair.
- oSum  out  SW  signed sum of all NTAP taps.
- oValid  out  1  one-cycle pulse qualifying oSum.
- oFull  out  1  level; chain holds NTAP accepted samples.

Function
REQ-005 Accept edge N: tap[0] <= iFirIn, tap[i] <= tap[i-1] for 1<=i<NTAP, in one edge.
REQ-006 No accept: taps, fill counter and oPair hold.
REQ-007 Edge N+1: oPair registered from post-shift taps; oPairValid high for exactly cycle N+1..N+2 when oFull.
REQ-008 Edge N+2: oSum registered as sum of the oPair slices; oValid high one cycle when the sample of edge N filled or kept the chain full.
REQ-009 Pair adds at DW+1 bits, sum at SW bits, all signed; no truncation, saturation or overflow for any input (DW=3, NTAP=21: range -84..+63).
REQ-010 Fill counter counts accepts, saturates at NTAP; oFull = (count==NTAP).
REQ-011 No oPairValid/oValid pulse before the chain is full; oPair/oSum still update.
REQ-012 Back-to-back accepts every cycle: pipeline delivers one oSum per accept, in order, latency 2.
REQ-013 iClear high: taps, counter, oPair, oSum, both valids cleared at next edge; iClear beats a simultaneous accept (sample dropped).
REQ-014 In-flight pipeline results at iClear or reset are discarded; no stale valid pulse afterwards.
REQ-015 X or unknown on iFirIn while no accept SHALL not propagate.

Reset
REQ-016 iRsn low asynchronously forces: all taps 0, counter 0, oPair 0, oSum 0, oPairValid 0, oValid 0, oFull 0.
REQ-017 Release synchronous to iClk12M via existing reset synchroniser; first accept permitted on first edge after release.
REQ-018 Reset mid-fill or mid-pipeline: behaves exactly as from power-up.

Structure
REQ-019 Package sym_fold_pkg holds clog2 function, default DW/NTAP, and slice-index helper for oPair.
REQ-020 Sub-module fold_pair_add: one registered signed pre-adder (DW in x2, DW+1 out, enable, clear), instantiated H times via generate; centre tap via sign-extend register.
REQ-021 Parameter check (odd NTAP, DW>=2) in elaboration assertion.

Verification (DW=3, NTAP=21)
REQ-022 Impulse: accept 1 then 20 zeros -> on the 21st accept oValid pulse at N+2 with oSum=1, oFull=1; slice 0 = 1.
REQ-023 Constant -4 x21 -> oSum=-84, every pair slice -8, centre -4; constant +3 x21 -> oSum=+63, pairs +6.
REQ-024 iEnSample600k pulses with iEnDelay=0 -> no tap change, no valid; with iClear and accept same cycle -> all zero, counter 0.
REQ-025 Continuous accepts every cycle ramp -4..3 wrapping -> oSum matches reference model each cycle, latency 2, no gaps.
REQ-026 Assert iRsn low after 10 accepts, mid-pipeline -> all outputs 0 immediately, no oValid; refill needs 21 new accepts.
